mem_stage_ctrl: RTL

Memory-stage controller between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Issues loads and stores to a multi-cycle data memory using a req/stall/done handshake.
- Freezes the upstream pipeline while an access is outstanding.
- Produces the read data and the enable for the MEM/WB register.
- Flags misaligned, conflicting or timed-out accesses as a sticky error that freezes the pipe.

---
 rtl/mem_stage_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues loads/stores over a req/stall/done handshake,
// freezes the upstream pipe while an access is outstanding, and flags sticky errors.
module mem_stage_ctrl #(
  parameter int MAX_WAIT = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [15:0] addr_in,
  input  logic [15:0] wdata_in,
  output logic        dmem_req,
  output logic        dmem_wr,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_stall,
  input  logic        dmem_done,
  input  logic [15:0] dmem_rdata,
  output logic        stall_out,
  output logic        wb_en,
  output logic [15:0] read_data_out,
  output logic        err_out
);

  localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ERR} state_t;

  state_t      r_state, w_state_next;
  logic [7:0]  r_cnt, w_cnt_next;
  logic [15:0] r_addr, r_wdata, r_rdata_q;
  logic        r_wr;
  logic        w_access, w_illegal, w_latch, w_capture;

  assign w_access  = valid_in & (mem_read_in | mem_write_in);
  assign w_illegal = (mem_read_in & mem_write_in) | addr_in[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_addr    <= 16'd0;
      r_wdata   <= 16'd0;
      r_wr      <= 1'b0;
      r_rdata_q <= 16'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_latch) begin
        r_addr  <= addr_in;
        r_wdata <= wdata_in;
        r_wr    <= mem_write_in;
      end
      if (w_capture) r_rdata_q <= dmem_rdata;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_latch       = 1'b0;
    w_capture     = 1'b0;
    dmem_req      = 1'b0;
    dmem_wr       = r_wr;
    dmem_addr     = r_addr;
    dmem_wdata    = r_wdata;
    stall_out     = 1'b0;
    wb_en         = 1'b0;
    read_data_out = r_rdata_q;
    err_out       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!w_access) begin
          wb_en = 1'b1;
        end else if (w_illegal) begin
          stall_out    = 1'b1;
          w_state_next = S_ERR;
        end else begin
          dmem_req     = 1'b1;
          dmem_wr      = mem_write_in;
          dmem_addr    = addr_in;
          dmem_wdata   = wdata_in;
          stall_out    = 1'b1;
          w_latch      = 1'b1;
          w_cnt_next   = 8'd1;
          w_state_next = dmem_stall ? S_REQ : S_WAIT;
        end
      end
      S_REQ: begin
        dmem_req  = 1'b1;
        stall_out = 1'b1;
        if (r_cnt == LP_MAX_WAIT) begin
          w_state_next = S_ERR;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
          if (!dmem_stall) w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        stall_out = 1'b1;
        // A completion in the same cycle the count expires still wins.
        if (dmem_done) begin
          stall_out    = 1'b0;
          wb_en        = 1'b1;
          w_cnt_next   = 8'd0;
          w_state_next = S_IDLE;
          if (!r_wr) begin
            read_data_out = dmem_rdata;
            w_capture     = 1'b1;
          end
        end else if (r_cnt == LP_MAX_WAIT) begin
          w_state_next = S_ERR;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      S_ERR: begin
        err_out   = 1'b1;
        stall_out = 1'b1;
      end
      default: w_state_next = S_IDLE;
    endcase

    // Outputs are forced low while reset is held, including the combinational IDLE paths.
    if (rst) begin
      dmem_req      = 1'b0;
      dmem_wr       = 1'b0;
      dmem_addr     = 16'd0;
      dmem_wdata    = 16'd0;
      stall_out     = 1'b0;
      wb_en         = 1'b0;
      read_data_out = 16'd0;
      err_out       = 1'b0;
      w_latch       = 1'b0;
      w_capture     = 1'b0;
    end
  end

endmodule
